// File: rtl/shared_instruction_memory_pkg.sv
// Shared project constants for the instruction memory and its round-robin arbiter.
// Imported by the multiprocessor top so every block agrees on word, address and port sizes.
package shared_instruction_memory_pkg;

    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_N_PORTS = 2;

    // A single-port arbiter still needs a 1-bit pointer register.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one requesting core per enabled cycle, searching from the
// core after the last one granted. The pointer only moves on a cycle that issues a grant.
module rr_arbiter
    import shared_instruction_memory_pkg::*;
#(
    parameter int unsigned N_PORTS = DEF_N_PORTS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt
);

    localparam int unsigned PTR_W = ptr_width(N_PORTS);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   pick;
    logic [N_PORTS-1:0] masked;

    always_comb begin
        masked = '0;
        pick   = ptr_q;
        gnt    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            masked[i] = req[i] && (i > int'(ptr_q));
        end
        // Lowest requester above the pointer wins; otherwise wrap to the lowest requester.
        if (|masked) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (masked[i]) pick = PTR_W'(i);
            end
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (req[i]) pick = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            gnt[i] = enable && (|req) && (pick == PTR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(N_PORTS - 1);
        end else if (|gnt) begin
            ptr_q <= pick;
        end
    end

endmodule

// File: rtl/shared_instruction_memory.sv
// Instruction RAM shared by N_PORTS cores plus a loader port. The loader always wins;
// otherwise one core per cycle is granted and receives its word one cycle later.
module shared_instruction_memory
    import shared_instruction_memory_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned N_PORTS = DEF_N_PORTS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_we,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [DATA_W-1:0]         load_data,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    output logic [N_PORTS-1:0]        gnt,
    output logic [N_PORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic              arb_en;

    assign arb_en = rst_n & ~load_we;

    rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (arb_en),
        .req    (req),
        .gnt    (gnt)
    );

    // gnt is one-hot or zero, so OR-ing the masked addresses selects the winner.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) rd_addr = rd_addr | addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Storage is never reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (rst_n && load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt;
            if (|gnt) begin
                rdata <= mem[rd_addr];
            end
        end
    end

endmodule
